// File: rtl/text_vram.sv
// text_vram: Wishbone slave character/attribute memory.
// Two slave ports (V: read-only video fetch, C: read/write CPU) share one
// single-port RAM through a small arbiter that favours V but guarantees C is
// served after at most two consecutive V grants.
// Optional power-up clear sweep: define TEXT_VRAM_CLEAR_EN.
module text_vram #(
    parameter int          AWIDTH = 10,
    parameter logic [31:0] FILL   = 32'hFF20_FF20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        v_cyc,
    input  logic        v_stb,
    input  logic [31:0] v_adr,
    output logic [31:0] v_dat_o,
    output logic        v_ack,
    input  logic        c_cyc,
    input  logic        c_stb,
    input  logic        c_we,
    input  logic [3:0]  c_sel,
    input  logic [31:0] c_adr,
    input  logic [31:0] c_dat_i,
    output logic [31:0] c_dat_o,
    output logic        c_ack,
    output logic        busy
);

    localparam int DEPTH = 1 << AWIDTH;

`ifdef TEXT_VRAM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK, S_CLEAR} state_t;
    localparam state_t S_RESET    = S_CLEAR;
    localparam logic   BUSY_RESET = 1'b1;
    logic [AWIDTH-1:0] clr_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK} state_t;
    localparam state_t S_RESET    = S_IDLE;
    localparam logic   BUSY_RESET = 1'b0;
`endif

    state_t      state;
    logic [1:0]  starve_cnt;   // consecutive V wins while C was waiting
    logic        pend_v;       // V strobe seen while C owned the RAM
    logic        owner_c;      // port currently in service (1 = C)
    logic        oob_reg;      // latched out-of-range flag of the request

    // Address decode: range check on the full address, then truncate.
    logic [AWIDTH-1:0] v_idx, c_idx;
    logic              v_oob, c_oob;
    logic              unused_adr_bits;
    assign v_idx = v_adr[AWIDTH+1:2];
    assign c_idx = c_adr[AWIDTH+1:2];
    assign v_oob = |v_adr[31:AWIDTH+2];
    assign c_oob = |c_adr[31:AWIDTH+2];
    assign unused_adr_bits = ^{v_adr[1:0], c_adr[1:0]};

    // Arbitration: V by default, C once V has starved it twice.
    logic v_req, c_req, c_win, v_win, owner_cyc;
    assign v_req     = v_cyc & (v_stb | pend_v);
    assign c_req     = c_cyc & c_stb;
    assign c_win     = c_req & (~v_req | (starve_cnt == 2'd2));
    assign v_win     = v_req & ~c_win;
    assign owner_cyc = owner_c ? c_cyc : v_cyc;

    // RAM port signals
    logic [AWIDTH-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;

    // RAM port mux: bus address in idle so read data is ready one clock later.
    always_comb begin
        ram_addr  = c_win ? c_idx : v_idx;
        ram_we    = 1'b0;
        ram_be    = c_sel;
        ram_wdata = c_dat_i;
        if (state == S_IDLE) begin
            ram_we = c_win & c_we & ~c_oob;
        end
`ifdef TEXT_VRAM_CLEAR_EN
        if (state == S_CLEAR) begin
            ram_addr  = clr_cnt;
            ram_we    = 1'b1;
            ram_be    = 4'hF;
            ram_wdata = FILL;
        end
`endif
    end

    // One byte-wide RAM per lane so each lane infers its own block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] lane_q;
            // Byte-lane write and registered read.
            always_ff @(posedge clk_i) begin
                if (ram_we && ram_be[gi]) begin
                    lane_mem[ram_addr] <= ram_wdata[gi*8 +: 8];
                end
                lane_q <= lane_mem[ram_addr];
            end
            assign ram_q[gi*8 +: 8] = lane_q;
        end
    endgenerate

    // Arbiter/handshake FSM with registered acks, data and busy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_RESET;
            busy       <= BUSY_RESET;
            starve_cnt <= 2'd0;
            pend_v     <= 1'b0;
            owner_c    <= 1'b0;
            oob_reg    <= 1'b0;
            v_ack      <= 1'b0;
            c_ack      <= 1'b0;
            v_dat_o    <= 32'h0;
            c_dat_o    <= 32'h0;
`ifdef TEXT_VRAM_CLEAR_EN
            clr_cnt    <= '0;
`endif
        end else begin
            v_ack <= 1'b0;
            c_ack <= 1'b0;
            pend_v <= owner_c & v_cyc & (pend_v | v_stb);
            case (state)
                S_IDLE: begin
                    pend_v <= c_win & v_req;
                    if (c_win) begin
                        owner_c    <= 1'b1;
                        oob_reg    <= c_oob;
                        starve_cnt <= 2'd0;
                        busy       <= 1'b1;
                        if (c_we) begin
                            c_ack <= 1'b1;
                            state <= S_ACK;
                        end else begin
                            state <= S_RD;
                        end
                    end else if (v_win) begin
                        owner_c <= 1'b0;
                        oob_reg <= v_oob;
                        busy    <= 1'b1;
                        state   <= S_RD;
                        if (c_req) begin
                            starve_cnt <= starve_cnt + 2'd1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_RD: begin
                    if (!owner_cyc) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_ACK;
                        if (owner_c) begin
                            c_ack   <= 1'b1;
                            c_dat_o <= oob_reg ? 32'h0 : ram_q;
                        end else begin
                            v_ack   <= 1'b1;
                            v_dat_o <= oob_reg ? 32'h0 : ram_q;
                        end
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
`ifdef TEXT_VRAM_CLEAR_EN
                S_CLEAR: begin
                    pend_v  <= 1'b0;
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_vram.sv
// tb_text_vram: directed self-checking bench for text_vram.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_text_vram;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        v_cyc, v_stb;
    logic [31:0] v_adr;
    logic [31:0] v_dat_o;
    logic        v_ack;
    logic        c_cyc, c_stb, c_we;
    logic [3:0]  c_sel;
    logic [31:0] c_adr, c_dat_i;
    logic [31:0] c_dat_o;
    logic        c_ack;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    text_vram #(.AWIDTH(10), .FILL(32'hFF20_FF20)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .v_cyc   (v_cyc),
        .v_stb   (v_stb),
        .v_adr   (v_adr),
        .v_dat_o (v_dat_o),
        .v_ack   (v_ack),
        .c_cyc   (c_cyc),
        .c_stb   (c_stb),
        .c_we    (c_we),
        .c_sel   (c_sel),
        .c_adr   (c_adr),
        .c_dat_i (c_dat_i),
        .c_dat_o (c_dat_o),
        .c_ack   (c_ack),
        .busy    (busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic c_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b1; c_adr = adr; c_dat_i = dat; c_sel = sel;
        tick();
        check("wr_ack_1clk", {31'h0, c_ack}, 32'h1);
        check("wr_busy", {31'h0, busy}, 32'h1);
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0;
        tick();
        check("wr_ack_single", {31'h0, c_ack}, 32'h0);
    endtask

    task automatic c_read(input logic [31:0] adr, output logic [31:0] dat);
        c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b0; c_adr = adr; c_sel = 4'hF;
        tick();
        check("rd_ack_not_early", {31'h0, c_ack}, 32'h0);
        check("rd_busy", {31'h0, busy}, 32'h1);
        c_stb = 1'b0;
        tick();
        check("rd_ack_2clk", {31'h0, c_ack}, 32'h1);
        dat = c_dat_o;
        c_cyc = 1'b0;
        tick();
        check("rd_ack_single", {31'h0, c_ack}, 32'h0);
    endtask

    // C read held while V pulses every 3 clocks; C must get in after 2 V acks,
    // then the V strobe that arrived during C's service is served from pending.
    task automatic run_starve(input string tag);
        int  vacks;
        int  packs;
        bit  seen;
        vacks = 0; seen = 1'b0; packs = 0;
        c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b0; c_adr = 32'h20;
        v_cyc = 1'b1; v_adr = 32'h10;
        for (int k = 0; k < 30 && !seen; k++) begin
            v_stb = (k % 3 == 0);
            tick();
            if (v_ack) vacks++;
            if (c_ack) seen = 1'b1;
        end
        v_stb = 1'b0; c_stb = 1'b0; c_cyc = 1'b0;
        check({tag, "_cack_seen"}, {31'h0, seen}, 32'h1);
        check({tag, "_vacks_before_c"}, vacks, 32'd2);
        check({tag, "_c_data"}, c_dat_o, 32'h11BB_11DD);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (v_ack) packs++;
        end
        check({tag, "_pending_v_acks"}, packs, 32'd1);
        check({tag, "_pending_v_data"}, v_dat_o, 32'h1234_5678);
        v_cyc = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          cnt;
        rst_i = 1'b1;
        v_cyc = 1'b0; v_stb = 1'b0; v_adr = 32'h0;
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0; c_sel = 4'h0; c_adr = 32'h0; c_dat_i = 32'h0;
        tick();
        tick();
        check("rst_v_ack", {31'h0, v_ack}, 32'h0);
        check("rst_c_ack", {31'h0, c_ack}, 32'h0);
        check("rst_v_dat", v_dat_o, 32'h0);
        check("rst_c_dat", c_dat_o, 32'h0);
`ifdef TEXT_VRAM_CLEAR_EN
        check("rst_busy", {31'h0, busy}, 32'h1);
        rst_i = 1'b0;
        cnt = 0;
        v_cyc = 1'b1; v_adr = 32'h40;
        for (int k = 0; k < 2000; k++) begin
            v_stb = (k < 5);
            tick();
            cnt++;
            if (v_ack) check("clr_no_ack", {31'h0, v_ack}, 32'h0);
            if (!busy) break;
        end
        v_stb = 1'b0;
        check("clr_busy_clocks", cnt, 32'd1024);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (v_ack) cnt++;
        end
        check("clr_pending_dropped", cnt, 32'd0);
        v_stb = 1'b1;
        tick();
        v_stb = 1'b0;
        tick();
        check("clr_v_ack", {31'h0, v_ack}, 32'h1);
        check("clr_fill", v_dat_o, 32'hFF20_FF20);
        v_cyc = 1'b0;
        tick();
`else
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst_i = 1'b0;
        tick();
`endif
        // full-word write then read back
        c_write(32'h10, 32'h1234_5678, 4'hF);
        c_read(32'h10, rd);
        check("rd_word_0x10", rd, 32'h1234_5678);

        // byte-lane write over a known word
        c_write(32'h20, 32'h1111_1111, 4'hF);
        c_write(32'h20, 32'hAABB_CCDD, 4'b0101);
        c_read(32'h20, rd);
        check("byte_lane_merge", rd, 32'h11BB_11DD);

        // single-cycle V strobe, v_cyc held: one ack, two clocks later
        v_cyc = 1'b1; v_stb = 1'b1; v_adr = 32'h10;
        tick();
        v_stb = 1'b0;
        check("v_ack_not_early", {31'h0, v_ack}, 32'h0);
        tick();
        check("v_ack_2clk", {31'h0, v_ack}, 32'h1);
        check("v_pulse_data", v_dat_o, 32'h1234_5678);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (v_ack) cnt++;
        end
        check("v_no_second_ack", cnt, 32'd0);
        check("idle_busy_low", {31'h0, busy}, 32'h0);
        v_cyc = 1'b0;
        tick();

        // starvation bound, twice to show the counter was cleared
        run_starve("starve1");
        run_starve("starve2");

        // abort: cyc dropped before ack, no ack and data held
        c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b0; c_adr = 32'h10;
        tick();
        c_cyc = 1'b0; c_stb = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (c_ack) cnt++;
        end
        check("abort_no_ack", cnt, 32'd0);
        check("abort_c_dat_hold", c_dat_o, 32'h11BB_11DD);
        check("v_dat_hold", v_dat_o, 32'h1234_5678);

        // out of range: read returns zero, write is acked but dropped
        c_write(32'h0, 32'hDEAD_BEEF, 4'hF);
        c_read(32'h0000_1000, rd);
        check("oob_read_zero", rd, 32'h0);
        c_write(32'h0000_1000, 32'h5555_5555, 4'hF);
        c_read(32'h0, rd);
        check("oob_write_dropped", rd, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
